// File: rtl/sum_scheduler_if.sv
// Bundle of the requester-side and datapath-side signals of sum_scheduler.
// master: the scheduler itself. slave: the surrounding clients plus datapath.
interface sum_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_N;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [17:0]       result;
  logic              err;
  logic              busy;
  logic [7:0]        dp_N;
  logic              dp_N_valid;
  logic [17:0]       dp_Sum_out;
  logic              dp_Sum_valid;

  modport master (
    input  req, req_N, dp_Sum_out, dp_Sum_valid,
    output gnt, done, result, err, busy, dp_N, dp_N_valid
  );

  modport slave (
    output req, req_N, dp_Sum_out, dp_Sum_valid,
    input  gnt, done, result, err, busy, dp_N, dp_N_valid
  );
endinterface

// File: rtl/sum_scheduler.sv
// Round-robin scheduler sharing one sum-of-naturals datapath between NREQ
// requesters. N==0 is answered locally; a watchdog bounds the RUN state.
// Optional macro SUM_CHECK_EN: cross-check the datapath sum against
// N*(N+1)/2 and flag a mismatch on err (result still returns dp_Sum_out).
module sum_scheduler #(
  parameter int NREQ     = 4,
  parameter int WD_LIMIT = 260
) (
  input logic             Clk,
  input logic             Rst,
  sum_scheduler_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(WD_LIMIT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]      state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   idx_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] done_reg;
  logic [17:0]     result_reg;
  logic            err_reg;
  logic            busy_reg;
  logic [7:0]      dp_n_reg;
  logic            dp_n_valid_reg;
  logic [WW-1:0]   wd_cnt_reg;

  // Rotated arbitration view: candidate gi is requester (ptr + gi) mod NREQ
  logic [IW:0]     cand_sum [NREQ];
  logic [IW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0] cand_hit;
  logic [IW-1:0]   sel_idx;
  logic            any_req;
  logic [NREQ-1:0] sel_onehot;
  logic [7:0]      sel_n;
  logic [IW-1:0]   ptr_next;
  logic            sum_mismatch;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, ptr_reg} + (IW+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (IW+1)'(NREQ))
                            ? IW'(cand_sum[gi] - (IW+1)'(NREQ))
                            : cand_sum[gi][IW-1:0];
      assign cand_hit[gi] = bus.req[cand_idx[gi]];
      assign sel_onehot[gi] = (sel_idx == IW'(gi));
    end
  endgenerate

  // First requester at or after the pointer wins (lowest rotated offset)
  always_comb begin
    sel_idx = '0;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        sel_idx = cand_idx[i];
        any_req = 1'b1;
      end
    end
  end

  assign sel_n    = bus.req_N[{sel_idx, 3'b000} +: 8];
  assign ptr_next = (idx_reg == IW'(NREQ - 1)) ? '0 : idx_reg + IW'(1);

`ifdef SUM_CHECK_EN
  logic [16:0] chk_prod;
  logic [17:0] chk_expect;
  assign chk_prod     = {9'd0, dp_n_reg} * ({9'd0, dp_n_reg} + 17'd1);
  assign chk_expect   = 18'(chk_prod >> 1);
  assign sum_mismatch = (chk_expect != bus.dp_Sum_out);
`else
  assign sum_mismatch = 1'b0;
`endif

  // Scheduler FSM: accept, load pulse, wait with watchdog, respond
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      idx_reg        <= '0;
      gnt_reg        <= '0;
      done_reg       <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      dp_n_reg       <= '0;
      dp_n_valid_reg <= 1'b0;
      wd_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            idx_reg  <= sel_idx;
            gnt_reg  <= sel_onehot;
            busy_reg <= 1'b1;
            dp_n_reg <= sel_n;
            if (sel_n == 8'd0) begin
              result_reg <= '0;
              err_reg    <= 1'b0;
              done_reg   <= sel_onehot;
              state_reg  <= ST_RESP;
            end else begin
              dp_n_valid_reg <= 1'b1;
              state_reg      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          dp_n_valid_reg <= 1'b0;
          wd_cnt_reg     <= '0;
          state_reg      <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.dp_Sum_valid) begin
            result_reg <= bus.dp_Sum_out;
            err_reg    <= sum_mismatch;
            done_reg   <= gnt_reg;
            state_reg  <= ST_RESP;
          end else if (wd_cnt_reg == WW'(WD_LIMIT - 1)) begin
            result_reg <= '0;
            err_reg    <= 1'b1;
            done_reg   <= gnt_reg;
            state_reg  <= ST_RESP;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WW'(1);
          end
        end
        default: begin
          done_reg   <= '0;
          err_reg    <= 1'b0;
          gnt_reg    <= '0;
          busy_reg   <= 1'b0;
          wd_cnt_reg <= '0;
          ptr_reg    <= ptr_next;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.done       = done_reg;
  assign bus.result     = result_reg;
  assign bus.err        = err_reg;
  assign bus.busy       = busy_reg;
  assign bus.dp_N       = dp_n_reg;
  assign bus.dp_N_valid = dp_n_valid_reg;
endmodule
